// File: rtl/cnn_buf_pkg.sv
// Shared definitions for the CNN feature-map buffers:
// default geometry and the encoding of a bank's fill state.
package cnn_buf_pkg;

    localparam int DW_DEFAULT    = 16;    // bits per channel word
    localparam int CH_DEFAULT    = 16;    // channels per pixel word
    localparam int DEPTH_DEFAULT = 4096;  // pixel words per bank (holds a 55x55 map)

    typedef logic [1:0] bank_state_t;

    localparam logic [1:0] BANK_EMPTY   = 2'd0;
    localparam logic [1:0] BANK_FILLING = 2'd1;
    localparam logic [1:0] BANK_FULL    = 2'd2;

endpackage

// File: rtl/fmap_bank_ram.sv
// One feature-map bank: single clock, one write port, one registered read port.
module fmap_bank_ram #(
    parameter int WIDTH = 256,
    parameter int DEPTH = 4096,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_q;

    // Write on request; register the read word so the array maps onto block RAM.
    // NOTE: neither the array nor the read register has a reset; clearing a memory
    // needs DEPTH cycles and blocks RAM inference, and the controller masks stale data.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            r_rd_q <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_q;

endmodule

// File: rtl/fmap_pingpong_buffer.sv
// Two-bank ping-pong buffer for CNN feature maps: a producer fills one bank
// while a consumer randomly reads the other; banks swap on fill/release.
module fmap_pingpong_buffer
    import cnn_buf_pkg::*;
#(
    parameter int DW    = DW_DEFAULT,
    parameter int CH    = CH_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AW:0]      cfg_size,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [DW*CH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [DW*CH-1:0] rd_data,
    output logic             rd_valid,
    output logic             rd_avail,
    input  logic             rd_release,
    output logic [AW:0]      rd_size,
    output logic [1:0]       err
);

    localparam int          WW      = DW * CH;
    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    // Control state: one fill state and one latched size per bank.
    bank_state_t   r_state [2];
    logic [AW:0]   r_size  [2];
    logic          r_wr_bank;
    logic          r_rd_bank;
    logic [AW-1:0] r_wr_ptr;
    logic [1:0]    r_err;

    // Read pipeline: which bank was read and whether the request was legal.
    logic          r_rd_valid;
    logic          r_rd_ok;
    logic          r_rd_sel;

    bank_state_t   w_wr_state;
    logic [AW:0]   w_wr_size;
    logic          w_size_ok;
    logic          w_wr_acc;
    logic          w_wr_last;
    logic          w_cfg_bad;
    logic          w_release;
    logic          w_rd_ok;
    logic [1:0]    w_wr_en;
    logic [1:0]    w_rd_en;
    logic [WW-1:0] w_ram_q [2];

    // Handshake, bank-swap conditions and read legality from the current state.
    // NOTE: every signal here is assigned on every pass, so no latch can be inferred.
    always_comb begin
        w_wr_state = r_state[r_wr_bank];
        // An empty bank takes its size from cfg_size; a filling bank keeps its latched size.
        w_wr_size  = (w_wr_state == BANK_EMPTY) ? cfg_size : r_size[r_wr_bank];
        w_size_ok  = (w_wr_size != '0) && (w_wr_size <= DEPTH_W);
        wr_ready   = (w_wr_state != BANK_FULL) && w_size_ok && !r_err[0];
        w_wr_acc   = wr_valid && wr_ready;
        w_wr_last  = ({1'b0, r_wr_ptr} == (w_wr_size - 1'b1));
        w_cfg_bad  = wr_valid && (w_wr_state == BANK_EMPTY) && !w_size_ok;

        rd_avail   = (r_state[r_rd_bank] == BANK_FULL);
        rd_size    = rd_avail ? r_size[r_rd_bank] : '0;
        w_release  = rd_release && rd_avail;
        w_rd_ok    = rd_en && rd_avail && ({1'b0, rd_addr} < rd_size);

        w_wr_en    = {w_wr_acc && r_wr_bank, w_wr_acc && !r_wr_bank};
        w_rd_en    = {w_rd_ok && r_rd_bank, w_rd_ok && !r_rd_bank};

        // Illegal reads return zero; the RAM register is not reset, so it is masked here too.
        rd_data    = r_rd_ok ? w_ram_q[r_rd_sel] : '0;
    end

    // Bank state machine, write pointer, size latches and sticky error flags.
    // NOTE: sequential state uses non-blocking assignments so every register
    // sees pre-edge values, regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state[0] <= BANK_EMPTY;
            r_state[1] <= BANK_EMPTY;
            r_size[0]  <= '0;
            r_size[1]  <= '0;
            r_wr_bank  <= 1'b0;
            r_rd_bank  <= 1'b0;
            r_wr_ptr   <= '0;
            r_err      <= 2'b00;
        end else begin
            // The write bank is never FULL when a write is accepted and the read bank
            // is always FULL when released, so these two updates hit different banks.
            if (w_wr_acc) begin
                if (w_wr_state == BANK_EMPTY) begin
                    r_size[r_wr_bank] <= cfg_size;
                end
                if (w_wr_last) begin
                    r_state[r_wr_bank] <= BANK_FULL;
                    r_wr_ptr           <= '0;
                    r_wr_bank          <= ~r_wr_bank;
                end else begin
                    r_state[r_wr_bank] <= BANK_FILLING;
                    r_wr_ptr           <= r_wr_ptr + 1'b1;
                end
            end
            if (w_release) begin
                r_state[r_rd_bank] <= BANK_EMPTY;
                r_rd_bank          <= ~r_rd_bank;
            end
            r_err[0] <= r_err[0] | w_cfg_bad;
            r_err[1] <= r_err[1] | (rd_en && !w_rd_ok);
        end
    end

    // Read pipeline: capture the pre-release bank so a same-cycle release cannot redirect a read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_valid <= 1'b0;
            r_rd_ok    <= 1'b0;
            r_rd_sel   <= 1'b0;
        end else begin
            r_rd_valid <= rd_en;
            r_rd_ok    <= w_rd_ok;
            r_rd_sel   <= r_rd_bank;
        end
    end

    assign rd_valid = r_rd_valid;
    assign err      = r_err;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        fmap_bank_ram #(
            .WIDTH (WW),
            .DEPTH (DEPTH),
            .AW    (AW)
        ) u_ram (
            .clk       (clk),
            .i_wr_en   (w_wr_en[b]),
            .i_wr_addr (r_wr_ptr),
            .i_wr_data (wr_data),
            .i_rd_en   (w_rd_en[b]),
            .i_rd_addr (rd_addr),
            .o_rd_data (w_ram_q[b])
        );
    end

endmodule

// File: tb/tb_fmap_pingpong_buffer.sv
// Self-checking bench for fmap_pingpong_buffer: a reference model of the two
// banks predicts handshake outputs each cycle and queues expected read data.
module tb_fmap_pingpong_buffer;

    localparam int DW    = 16;
    localparam int CH    = 16;
    localparam int DEPTH = 4096;
    localparam int AW    = 12;
    localparam int WW    = DW * CH;

    typedef logic [WW-1:0] word_t;
    typedef struct {
        int    due;
        word_t data;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [AW:0]   cfg_size = '0;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    word_t         wr_data = '0;
    logic          rd_en = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    word_t         rd_data;
    logic          rd_valid;
    logic          rd_avail;
    logic          rd_release = 1'b0;
    logic [AW:0]   rd_size;
    logic [1:0]    err;

    always #5 clk = ~clk;

    fmap_pingpong_buffer #(
        .DW    (DW),
        .CH    (CH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_size   (cfg_size),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_data    (wr_data),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .rd_avail   (rd_avail),
        .rd_release (rd_release),
        .rd_size    (rd_size),
        .err        (err)
    );

    int    n_checks = 0;
    int    n_errors = 0;
    int    cyc      = 0;
    exp_t  sb [$];

    // Reference model: 0 = empty, 1 = filling, 2 = full.
    int    m_state [2];
    int    m_size  [2];
    int    m_wr, m_rd, m_ptr;
    bit    m_err0, m_err1;
    word_t m_mem [int];

    task automatic check(input string tag, input word_t got, input word_t exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic word_t rnd_word();
        word_t w;
        for (int k = 0; k < WW / 32; k++) w[k*32 +: 32] = $urandom;
        return w;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Every queued read must come back exactly one cycle after it was issued.
    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].due == cyc) begin
            check("rd_valid", word_t'(rd_valid), word_t'(1));
            check("rd_data", rd_data, sb[0].data);
            void'(sb.pop_front());
        end else if (rd_valid) begin
            check("rd_valid_spurious", word_t'(rd_valid), word_t'(0));
        end
    end

    // One clock cycle of stimulus; checks outputs against the model, then advances the model.
    task automatic drive(input bit wv, input word_t wd, input int cs,
                         input bit re, input int ra, input bit rr);
        int  used, rsize;
        bit  ready, avail, ok, last;
        exp_t e;
        @(negedge clk);
        wr_valid   = wv;
        wr_data    = wd;
        cfg_size   = cs[AW:0];
        rd_en      = re;
        rd_addr    = ra[AW-1:0];
        rd_release = rr;
        #1;
        used  = (m_state[m_wr] == 0) ? cs : m_size[m_wr];
        ready = (m_state[m_wr] != 2) && (used >= 1) && (used <= DEPTH) && !m_err0;
        avail = (m_state[m_rd] == 2);
        rsize = avail ? m_size[m_rd] : 0;
        check("wr_ready", word_t'(wr_ready), word_t'(ready));
        check("rd_avail", word_t'(rd_avail), word_t'(avail));
        check("rd_size", word_t'(rd_size), word_t'(rsize));
        check("err", word_t'(err), word_t'({m_err1, m_err0}));
        if (re) begin
            ok     = avail && (ra < rsize);
            e.due  = cyc + 1;
            e.data = ok ? m_mem[m_rd * DEPTH + ra] : '0;
            sb.push_back(e);
            if (!ok) m_err1 = 1'b1;
        end
        if (wv && m_state[m_wr] == 0 && !(used >= 1 && used <= DEPTH)) m_err0 = 1'b1;
        if (wv && ready) begin
            if (m_state[m_wr] == 0) m_size[m_wr] = cs;
            m_mem[m_wr * DEPTH + m_ptr] = wd;
            last = (m_ptr == used - 1);
            if (last) begin
                m_state[m_wr] = 2;
                m_ptr         = 0;
                m_wr          = 1 - m_wr;
            end else begin
                m_state[m_wr] = 1;
                m_ptr++;
            end
        end
        if (rr && avail) begin
            m_state[m_rd] = 0;
            m_rd          = 1 - m_rd;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, '0, 0, 1'b0, 0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst        = 1'b0;
        wr_valid   = 1'b0;
        rd_en      = 1'b0;
        rd_release = 1'b0;
        cfg_size   = '0;
        #1;
        m_state = '{0, 0};
        m_size  = '{0, 0};
        m_wr    = 0;
        m_rd    = 0;
        m_ptr   = 0;
        m_err0  = 1'b0;
        m_err1  = 1'b0;
        sb.delete();
        check("rst_rd_valid", word_t'(rd_valid), '0);
        check("rst_rd_data", rd_data, '0);
        check("rst_err", word_t'(err), '0);
        check("rst_rd_avail", word_t'(rd_avail), '0);
        check("rst_rd_size", word_t'(rd_size), '0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        word_t w;

        // Normal fill of four words 0x1..0x4, then read them back.
        do_reset();
        drive(1'b0, '0, 4, 1'b0, 0, 1'b0);
        check("rst_wr_ready", word_t'(wr_ready), word_t'(1));
        for (int i = 1; i <= 4; i++) drive(1'b1, word_t'(i), 4, 1'b0, 0, 1'b0);
        for (int i = 0; i < 4; i++) drive(1'b0, '0, 0, 1'b1, i, 1'b0);
        idle(2);
        check("fill4_rd_size", word_t'(rd_size), word_t'(4));
        drive(1'b0, '0, 0, 1'b0, 0, 1'b1);
        idle(1);

        // Bad sizes: zero and larger than DEPTH set the sticky cfg error.
        do_reset();
        drive(1'b1, rnd_word(), 0, 1'b0, 0, 1'b0);
        idle(1);
        check("cfg0_err", word_t'(err), word_t'(2'b01));
        drive(1'b1, rnd_word(), 4, 1'b0, 0, 1'b0);
        check("cfg0_sticky_ready", word_t'(wr_ready), word_t'(0));
        do_reset();
        drive(1'b1, rnd_word(), DEPTH + 1, 1'b0, 0, 1'b0);
        idle(1);
        check("cfg_big_err", word_t'(err), word_t'(2'b01));

        // Out-of-range read of a four-word map.
        do_reset();
        for (int i = 0; i < 4; i++) drive(1'b1, rnd_word(), 4, 1'b0, 0, 1'b0);
        drive(1'b0, '0, 0, 1'b1, 5, 1'b0);
        idle(2);
        check("oor_err", word_t'(err), word_t'(2'b10));

        // Ping-pong overlap with a full 55x55 map: fill bank1 while reading bank0.
        do_reset();
        for (int i = 0; i < 3025; i++) drive(1'b1, rnd_word(), 3025, 1'b0, 0, 1'b0);
        for (int i = 0; i < 3025; i++) drive(1'b1, rnd_word(), 3025, 1'b1, i, 1'b0);
        drive(1'b0, '0, 0, 1'b0, 0, 1'b1);
        drive(1'b0, '0, 0, 1'b1, 3024, 1'b0);
        drive(1'b0, '0, 0, 1'b1, 0, 1'b0);
        idle(2);
        check("pp_rd_avail", word_t'(rd_avail), word_t'(1));
        check("pp_rd_size", word_t'(rd_size), word_t'(3025));

        // Backpressure: both banks full, then a release with a write held pending.
        do_reset();
        for (int i = 0; i < 4; i++) drive(1'b1, rnd_word(), 2, 1'b0, 0, 1'b0);
        w = rnd_word();
        drive(1'b1, w, 2, 1'b0, 0, 1'b0);
        check("bp_ready_low", word_t'(wr_ready), word_t'(0));
        drive(1'b1, w, 2, 1'b0, 0, 1'b1);
        drive(1'b1, w, 2, 1'b0, 0, 1'b0);
        check("bp_ready_back", word_t'(wr_ready), word_t'(1));
        drive(1'b1, rnd_word(), 2, 1'b0, 0, 1'b0);
        drive(1'b0, '0, 0, 1'b1, 0, 1'b0);
        drive(1'b0, '0, 0, 1'b1, 1, 1'b1);
        drive(1'b0, '0, 0, 1'b1, 0, 1'b0);
        drive(1'b0, '0, 0, 1'b1, 1, 1'b0);
        idle(2);

        // Final write of bank1 coincides with release of bank0.
        do_reset();
        for (int i = 0; i < 3; i++) drive(1'b1, rnd_word(), 2, 1'b0, 0, 1'b0);
        drive(1'b1, rnd_word(), 2, 1'b0, 0, 1'b1);
        drive(1'b0, '0, 2, 1'b1, 0, 1'b0);
        check("sim_rd_avail", word_t'(rd_avail), word_t'(1));
        check("sim_wr_ready", word_t'(wr_ready), word_t'(1));
        drive(1'b0, '0, 2, 1'b1, 1, 1'b1);
        idle(2);

        // Reset in the middle of a fill discards the partial map.
        do_reset();
        for (int i = 0; i < 2; i++) drive(1'b1, rnd_word(), 4, 1'b0, 0, 1'b0);
        do_reset();
        for (int i = 0; i < 4; i++) drive(1'b1, rnd_word(), 4, 1'b0, 0, 1'b0);
        for (int i = 0; i < 4; i++) drive(1'b0, '0, 0, 1'b1, i, 1'b0);
        idle(2);

        // Read with nothing available, then a single-pixel map.
        do_reset();
        drive(1'b0, '0, 0, 1'b1, 0, 1'b0);
        drive(1'b1, rnd_word(), 1, 1'b0, 0, 1'b0);
        drive(1'b0, '0, 0, 1'b1, 0, 1'b0);
        check("size1_rd_size", word_t'(rd_size), word_t'(1));
        drive(1'b0, '0, 0, 1'b1, 1, 1'b0);
        idle(2);
        check("size1_err", word_t'(err), word_t'(2'b10));

        check("sb_drained", word_t'(sb.size()), '0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/fmap_pingpong_buffer.md
FMAP_PINGPONG_BUFFER -- requirements
Module: fmap_pingpong_buffer

Interface
REQ-001 Parameter DW, default 16: bits per channel word.
REQ-002 Parameter CH, default 16: channels per pixel word.
REQ-003 Parameter DEPTH, default 4096: pixel words per bank; must be at least 55*55.
REQ-004 Parameter AW, default $clog2(DEPTH): address width.
REQ-005 Port clk, input, 1: single clock; all logic on its rising edge.
REQ-006 Port rst, input, 1: reset, asynchronous and active-low.
REQ-007 Port cfg_size, input, AW+1: pixels per feature map; sampled at the first write of each bank.
REQ-008 Port wr_valid, input, 1: producer presents wr_data.
REQ-009 Port wr_ready, output, 1: buffer accepts wr_data this cycle.
REQ-010 Port wr_data, input, DW*CH: one pixel of all channels; channel k sits at bits [k*DW +: DW].
REQ-011 Port rd_en, input, 1: consumer read request.
REQ-012 Port rd_addr, input, AW: pixel index in the read bank.
REQ-013 Port rd_data, output, DW*CH: read result.
REQ-014 Port rd_valid, output, 1: rd_data is valid.
REQ-015 Port rd_avail, output, 1: the read bank holds a complete map.
REQ-016 Port rd_release, input, 1: consumer has finished with the read bank.
REQ-017 Port rd_size, output, AW+1: latched size of the read bank.
REQ-018 Port err, output, 2: sticky flags. Bit0 = bad cfg_size; bit1 = out-of-range or unavailable read.

Function
REQ-019 Two banks SHALL each be tracked by a state: EMPTY, FILLING or FULL.
REQ-020 Write accept SHALL be wr_valid AND wr_ready.
REQ-021 wr_ready SHALL be 1 only when all of these hold: wr bank is EMPTY or FILLING; the cfg_size being used is valid (1..DEPTH); err bit0 is clear.
REQ-022 On an accept in an EMPTY bank, the bank SHALL latch cfg_size, store the word at address 0, and move to FILLING.
REQ-023 On an accept with write pointer equal to latched size minus 1, the bank SHALL go FULL, the pointer SHALL return to 0, and wr_bank SHALL toggle.
REQ-024 A size of 1 SHALL take the bank from EMPTY to FULL in one accept.
REQ-025 While wr_valid=1, a cfg_size of 0 or greater than DEPTH in an EMPTY bank SHALL set err bit0, and no data SHALL be written.
REQ-026 rd_avail SHALL be 1 exactly when the rd bank is FULL.
REQ-027 rd_size SHALL give the latched size of the rd bank, and 0 when the rd bank is not FULL.
REQ-028 When rd_en=1, rd_avail=1 and rd_addr < rd_size: rd_data SHALL be the stored word and rd_valid SHALL be 1 on the next cycle (one-cycle latency, fully pipelined, one read per cycle).
REQ-029 When rd_en=1 but rd_avail=0 or rd_addr >= rd_size: rd_valid SHALL be 1 next cycle with rd_data all zero, and err bit1 SHALL be set.
REQ-030 rd_release with rd_avail=1 SHALL set the rd bank to EMPTY and toggle rd_bank.
REQ-031 rd_release with rd_avail=0 SHALL be ignored.
REQ-032 If rd_en and rd_release occur in the same cycle, the read SHALL complete using the pre-release bank.
REQ-033 A final write and a release in the same cycle SHALL both take effect. Result: rd_avail=1 the next cycle when the bank just filled is the new rd bank.
REQ-034 When both banks are FULL, wr_ready SHALL be 0 until a release.
REQ-035 A write accepted in the cycle of a release SHALL NOT be dropped or duplicated.

Reset
REQ-036 Asserting rst (low) SHALL asynchronously clear everything: both banks EMPTY, wr_bank=0, rd_bank=0, pointer 0, latched sizes 0, err=0, rd_valid=0, rd_data=0.
REQ-037 After reset, outputs SHALL be: wr_ready=1 (subject to REQ-021), rd_avail=0, rd_size=0.
REQ-038 A reset in the middle of a fill SHALL discard that partial map.
REQ-039 Memory contents SHALL NOT be cleared by reset.

Structure
REQ-040 The bank state encoding and the DW/CH/DEPTH defaults SHALL live in shared package cnn_buf_pkg.
REQ-041 Storage SHALL use one sub-module, fmap_bank_ram: single-clock, one write port, one registered read port, DEPTH x DW*CH. It SHALL be instantiated twice.
REQ-042 Control (bank states, pointers, sizes) SHALL stay in the top module.

Verification
REQ-043 Scenario, normal fill and read: cfg_size=4, write 4 words 0x1..0x4, read addr 0..3 -> rd_avail=1 after the 4th accept; rd_data 0x1..0x4, each one cycle after rd_en.
REQ-044 Scenario, ping-pong overlap: fill bank0 (size 3025); while reading bank0, fill bank1; then release -> rd_avail stays 1 and rd_size=3025 for bank1; no wr_ready stall during the overlap.
REQ-045 Scenario, backpressure: fill both banks with size 2 and no release -> wr_ready=0; one rd_release -> wr_ready=1 on the next cycle.
REQ-046 Scenario, errors: cfg_size=0 with wr_valid -> err=2'b01 and wr_ready=0. After reset, read addr 5 with rd_size=4 -> rd_data=0, err=2'b10.
REQ-047 Scenario, simultaneous events: final write of bank1 in the same cycle as release of bank0 -> next cycle rd_bank=1, rd_avail=1, wr_bank=0, bank0 EMPTY.
REQ-048 Scenario, reset mid-fill: pull rst low after 2 of 4 words -> rd_avail=0 and the next write goes to bank0 at address 0.
